// File: rtl/fsm_input_sequencer_if.sv
// Symbol step handshake between the input sequencer and the FSM core.
//   sym       : symbol presented to the core (FIFO head)
//   sym_valid : sym holds a queued symbol
//   sym_ready : core consumes sym this cycle
// master = sequencer side, slave = core side.
interface fsm_input_sequencer_if #(
  parameter int unsigned SYM_W = 2
) ();
  logic [SYM_W-1:0] sym;
  logic             sym_valid;
  logic             sym_ready;

  modport master (output sym, output sym_valid, input sym_ready);
  modport slave  (input sym, input sym_valid, output sym_ready);
endinterface

// File: rtl/fsm_input_sequencer.sv
// Front-end controller for the Mealy FSM core: synchronises and debounces the active-low step
// button, samples the switch symbol on each clean press into a small FIFO and hands symbols to
// the core over a valid/ready handshake (one core step per press).
// Ports:
//   CLOCK_125_p   : clock, rising edge
//   rst_i         : synchronous active-high reset
//   btn_n_i       : raw step button, active-low
//   sw_i          : raw switch symbol
//   bus           : master side of the symbol handshake (sym, sym_valid out; sym_ready in)
//   fifo_count_o  : entries held, 0..DEPTH
//   overflow_o    : sticky, a press was dropped because the FIFO was full
//   replay_i      : replay request (FSM_REPLAY_EN only)
//   replay_busy_o : replay in progress (FSM_REPLAY_EN only)
// Optional feature: define FSM_REPLAY_EN to add the replay history ring.
module fsm_input_sequencer #(
  parameter int unsigned SYM_W           = 2,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned DB_CNT_W        = 21
) (
  input  logic                     CLOCK_125_p,
  input  logic                     rst_i,
  input  logic                     btn_n_i,
  input  logic [SYM_W-1:0]         sw_i,
  fsm_input_sequencer_if.master    bus,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o
`ifdef FSM_REPLAY_EN
  ,
  input  logic                     replay_i,
  output logic                     replay_busy_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [DB_CNT_W-1:0] DbLast = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

  typedef enum logic [1:0] {StRel, StPressWait, StPrs, StRelWait} db_state_e;

  // Synchronisers. The button sync resets to the released level so reset never fakes a press.
  logic             btn_s1_q, btn_s2_q;
  logic [SYM_W-1:0] sw_s1_q, sw_s2_q;

  always_ff @(posedge CLOCK_125_p) begin
    if (rst_i) begin
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_n_i;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_i;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Debounce FSM
  db_state_e             db_state_q;
  logic [DB_CNT_W-1:0]   db_cnt_q;
  logic                  db_done;
  logic                  btn_strobe;

  assign db_done    = (db_cnt_q == DbLast);
  // Strobe fires on the cycle the last stable low sample is counted, so the FIFO write
  // coincides with the PRESS_WAIT -> PRS transition.
  assign btn_strobe = (db_state_q == StPressWait) && !btn_s2_q && db_done;

  always_ff @(posedge CLOCK_125_p) begin
    if (rst_i) begin
      db_state_q <= StRel;
      db_cnt_q   <= '0;
    end else begin
      unique case (db_state_q)
        StRel: begin
          if (!btn_s2_q) begin
            db_state_q <= StPressWait;
            db_cnt_q   <= '0;
          end
        end
        StPressWait: begin
          if (btn_s2_q)     db_state_q <= StRel;
          else if (db_done) db_state_q <= StPrs;
          else              db_cnt_q   <= db_cnt_q + DB_CNT_W'(1);
        end
        StPrs: begin
          if (btn_s2_q) begin
            db_state_q <= StRelWait;
            db_cnt_q   <= '0;
          end
        end
        StRelWait: begin
          if (!btn_s2_q)    db_state_q <= StPrs;
          else if (db_done) db_state_q <= StRel;
          else              db_cnt_q   <= db_cnt_q + DB_CNT_W'(1);
        end
        default: db_state_q <= StRel;
      endcase
    end
  end

  // Push source selection
  logic             push;
  logic [SYM_W-1:0] push_data;
  logic             push_ok;

`ifdef FSM_REPLAY_EN
  logic [SYM_W-1:0] hist_q [DEPTH];
  logic [PTR_W-1:0] hist_wr_q, rp_idx_q;
  logic [CNT_W-1:0] hist_cnt_q, rp_left_q;
  logic             rp_busy_q, replay_q;
  logic             replay_rise;

  assign replay_rise = replay_i && !replay_q;

  // While replaying, button strobes are ignored and the ring feeds the FIFO whenever it has room.
  always_comb begin
    if (rp_busy_q) begin
      push      = (fifo_count_o != CntFull);
      push_data = hist_q[rp_idx_q];
    end else begin
      push      = btn_strobe;
      push_data = sw_s2_q;
    end
  end

  always_ff @(posedge CLOCK_125_p) begin
    if (rst_i) begin
      hist_wr_q  <= '0;
      hist_cnt_q <= '0;
      rp_idx_q   <= '0;
      rp_left_q  <= '0;
      rp_busy_q  <= 1'b0;
      replay_q   <= 1'b0;
    end else begin
      replay_q <= replay_i;
      // Only button presses enter the history; replayed symbols are not re-recorded.
      if (!rp_busy_q && push_ok) begin
        hist_q[hist_wr_q] <= push_data;
        hist_wr_q         <= hist_wr_q + PTR_W'(1);
        if (hist_cnt_q != CntFull) hist_cnt_q <= hist_cnt_q + CNT_W'(1);
      end
      if (rp_busy_q) begin
        if (push) begin
          rp_idx_q  <= rp_idx_q + PTR_W'(1);
          rp_left_q <= rp_left_q - CNT_W'(1);
          if (rp_left_q == CNT_W'(1)) rp_busy_q <= 1'b0;
        end
      end else if (replay_rise && hist_cnt_q != '0) begin
        rp_busy_q <= 1'b1;
        // Oldest entry; truncation maps a full ring back onto the write pointer.
        rp_idx_q  <= hist_wr_q - PTR_W'(hist_cnt_q);
        rp_left_q <= hist_cnt_q;
      end
    end
  end

  assign replay_busy_o = rp_busy_q;
`else
  assign push      = btn_strobe;
  assign push_data = sw_s2_q;
`endif

  // Symbol FIFO with registered head output
  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [SYM_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             pop, full;

  assign pop     = valid_q && bus.sym_ready;
  assign full    = (count_q == CntFull);
  assign push_ok = push && (!full || pop);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    valid_d = (count_d != '0);
    sym_d   = valid_d ? mem_d[rd_d] : '0;
    ovf_d   = ovf_q | (push && full && !pop);
  end

  always_ff @(posedge CLOCK_125_p) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge CLOCK_125_p) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sym       = sym_q;
  assign bus.sym_valid = valid_q;
  assign fifo_count_o  = count_q;
  assign overflow_o    = ovf_q;

endmodule
